// File: rtl/butterfly_limiter_if.sv
// rtl/butterfly_limiter_if.sv - stream handshake and data bundle for the butterfly stage
// slave is the butterfly side; master is the producer/consumer side.
interface butterfly_limiter_if #(
  parameter int DW = 8,
  parameter int IW = DW + 1,
  parameter int TW = 16
);
  logic                 s_axis_tvalid;
  logic                 s_axis_tready;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic signed [IW-1:0] a_re_i;
  logic signed [IW-1:0] a_im_i;
  logic signed [IW-1:0] b_re_i;
  logic signed [IW-1:0] b_im_i;
  logic signed [TW-1:0] w_re_i;
  logic signed [TW-1:0] w_im_i;
  logic signed [DW-1:0] y0_re_o;
  logic signed [DW-1:0] y0_im_o;
  logic signed [DW-1:0] y1_re_o;
  logic signed [DW-1:0] y1_im_o;
  logic [3:0]           sat_o;

  modport slave (
    input  s_axis_tvalid, m_axis_tready,
    input  a_re_i, a_im_i, b_re_i, b_im_i, w_re_i, w_im_i,
    output s_axis_tready, m_axis_tvalid,
    output y0_re_o, y0_im_o, y1_re_o, y1_im_o, sat_o
  );

  modport master (
    output s_axis_tvalid, m_axis_tready,
    output a_re_i, a_im_i, b_re_i, b_im_i, w_re_i, w_im_i,
    input  s_axis_tready, m_axis_tvalid,
    input  y0_re_o, y0_im_o, y1_re_o, y1_im_o, sat_o
  );
endinterface

// File: rtl/butterfly_limiter.sv
// rtl/butterfly_limiter.sv - radix-2 butterfly with halving, round-half-up and saturation
// Three stages (products, sums, round/limit) advance together when the output slot is free.
module butterfly_limiter #(
  parameter int DW = 8,
  parameter int IW = DW + 1,
  parameter int TW = 16
) (
  input  logic               clk,
  input  logic               rstn,
  butterfly_limiter_if.slave bus
);
  localparam int MW = IW + TW;
  localparam int SW = IW + TW + 2;
  localparam logic signed [SW-1:0] RND  = SW'(1) <<< (TW - 2);
  localparam logic signed [SW-1:0] MAXS = SW'((2 ** (DW - 1)) - 1);
  localparam logic signed [SW-1:0] MINS = -MAXS - SW'(1);

  logic                 v1, v2, v3;
  logic                 en;
  logic signed [MW-1:0] m_rr, m_ii, m_ri, m_ir;
  logic signed [SW-1:0] a_re_q, a_im_q, p_re_q, p_im_q;
  logic signed [SW-1:0] s0_re_q, s0_im_q, s1_re_q, s1_im_q;

  assign en                = !v3 || bus.m_axis_tready;
  assign bus.s_axis_tready = en;
  assign bus.m_axis_tvalid = v3;

  assign m_rr = MW'(bus.b_re_i) * MW'(bus.w_re_i);
  assign m_ii = MW'(bus.b_im_i) * MW'(bus.w_im_i);
  assign m_ri = MW'(bus.b_re_i) * MW'(bus.w_im_i);
  assign m_ir = MW'(bus.b_im_i) * MW'(bus.w_re_i);

  // Halve with round-half-up, then clamp; returns {sat, value}.
  function automatic logic [DW:0] limit(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] r;
    r = (s + RND) >>> (TW - 1);
    if (r > MAXS)      limit = {1'b1, MAXS[DW-1:0]};
    else if (r < MINS) limit = {1'b1, MINS[DW-1:0]};
    else               limit = {1'b0, r[DW-1:0]};
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      v3          <= 1'b0;
      a_re_q      <= '0;
      a_im_q      <= '0;
      p_re_q      <= '0;
      p_im_q      <= '0;
      s0_re_q     <= '0;
      s0_im_q     <= '0;
      s1_re_q     <= '0;
      s1_im_q     <= '0;
      bus.y0_re_o <= '0;
      bus.y0_im_o <= '0;
      bus.y1_re_o <= '0;
      bus.y1_im_o <= '0;
      bus.sat_o   <= '0;
    end else if (en) begin
      v1 <= bus.s_axis_tvalid;
      v2 <= v1;
      v3 <= v2;
      if (bus.s_axis_tvalid) begin
        a_re_q <= SW'(bus.a_re_i) <<< (TW - 2);
        a_im_q <= SW'(bus.a_im_i) <<< (TW - 2);
        p_re_q <= SW'(m_rr) - SW'(m_ii);
        p_im_q <= SW'(m_ri) + SW'(m_ir);
      end
      if (v1) begin
        s0_re_q <= a_re_q + p_re_q;
        s0_im_q <= a_im_q + p_im_q;
        s1_re_q <= a_re_q - p_re_q;
        s1_im_q <= a_im_q - p_im_q;
      end
      if (v2) begin
        {bus.sat_o[0], bus.y0_re_o} <= limit(s0_re_q);
        {bus.sat_o[1], bus.y0_im_o} <= limit(s0_im_q);
        {bus.sat_o[2], bus.y1_re_o} <= limit(s1_re_q);
        {bus.sat_o[3], bus.y1_im_o} <= limit(s1_im_q);
      end
    end
  end
endmodule

// File: tb/tb_butterfly_limiter.sv
// tb/tb_butterfly_limiter.sv - self-checking bench for butterfly_limiter
// Expected results are queued on acceptance and compared when the output slot is valid.
module tb_butterfly_limiter;
  localparam int DW = 8;
  localparam int IW = DW + 1;
  localparam int TW = 16;

  typedef struct {
    logic [7:0] y0r, y0i, y1r, y1i;
    logic [3:0] sat;
  } exp_t;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  int   popped;
  int   stalls;
  exp_t q[$];

  butterfly_limiter_if #(.DW(DW), .IW(IW), .TW(TW)) bus ();

  butterfly_limiter #(.DW(DW), .IW(IW), .TW(TW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [8:0] lim(input longint s);
    longint r;
    r = (s + 64'sd16384) >>> 15;
    if (r > 127)       lim = {1'b1, 8'h7f};
    else if (r < -128) lim = {1'b1, 8'h80};
    else               lim = {1'b0, r[7:0]};
  endfunction

  function automatic exp_t model(input longint ar, ai, br, bi, wr, wi);
    longint pr, pi;
    exp_t   e;
    pr = br * wr - bi * wi;
    pi = br * wi + bi * wr;
    {e.sat[0], e.y0r} = lim(ar * 16384 + pr);
    {e.sat[1], e.y0i} = lim(ai * 16384 + pi);
    {e.sat[2], e.y1r} = lim(ar * 16384 - pr);
    {e.sat[3], e.y1i} = lim(ai * 16384 - pi);
    return e;
  endfunction

  task automatic send(input int ar, ai, br, bi, wr, wi);
    bit ok;
    ok = 1'b0;
    bus.a_re_i = IW'(ar);
    bus.a_im_i = IW'(ai);
    bus.b_re_i = IW'(br);
    bus.b_im_i = IW'(bi);
    bus.w_re_i = TW'(wr);
    bus.w_im_i = TW'(wi);
    bus.s_axis_tvalid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.s_axis_tready) begin
        ok = 1'b1;
        break;
      end
      stalls++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_accept: s_axis_tready stayed 0, required 1 within 200 cycles");
    end else begin
      q.push_back(model(ar, ai, br, bi, wr, wi));
    end
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
  endtask

  task automatic send_random();
    int ar, ai, br, bi, wr, wi;
    ar = int'($urandom_range(0, 511)) - 256;
    ai = int'($urandom_range(0, 511)) - 256;
    br = int'($urandom_range(0, 511)) - 256;
    bi = int'($urandom_range(0, 511)) - 256;
    wr = int'($urandom_range(0, 65535)) - 32768;
    wi = int'($urandom_range(0, 65535)) - 32768;
    send(ar, ai, br, bi, wr, wi);
  endtask

  // Called right after send returns; counts edges from the accepting edge to m_axis_tvalid.
  task automatic wait_out(output int cyc);
    cyc = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.m_axis_tvalid) break;
      @(posedge clk);
      cyc++;
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && bus.m_axis_tvalid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: m_axis_tvalid=1 with no queued result, required 0");
        end else begin
          e = q[0];
          if ({bus.y0_re_o, bus.y0_im_o, bus.y1_re_o, bus.y1_im_o, bus.sat_o}
              !== {e.y0r, e.y0i, e.y1r, e.y1i, e.sat}) begin
            errors++;
            $display("FAIL out_data: got y0=(%0d,%0d) y1=(%0d,%0d) sat=%b, required y0=(%0d,%0d) y1=(%0d,%0d) sat=%b",
                     bus.y0_re_o, bus.y0_im_o, bus.y1_re_o, bus.y1_im_o, bus.sat_o,
                     $signed(e.y0r), $signed(e.y0i), $signed(e.y1r), $signed(e.y1i), e.sat);
          end
          if (bus.m_axis_tready) begin
            void'(q.pop_front());
            popped++;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.m_axis_tvalid, bus.s_axis_tready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_handshake: got m_tvalid,s_tready=%b, required 01",
               {bus.m_axis_tvalid, bus.s_axis_tready});
    end
    checks++;
    if ({bus.y0_re_o, bus.y0_im_o, bus.y1_re_o, bus.y1_im_o, bus.sat_o} !== 36'd0) begin
      errors++;
      $display("FAIL reset_data: got %h, required 0",
               {bus.y0_re_o, bus.y0_im_o, bus.y1_re_o, bus.y1_im_o, bus.sat_o});
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic test_unity();
    int cyc;
    send(64, 0, 64, 0, 16384, 0);
    wait_out(cyc);
    checks++;
    if (cyc !== 3) begin
      errors++;
      $display("FAIL unity_latency: got %0d cycles, required 3", cyc);
    end
    checks++;
    if ({bus.y0_re_o, bus.y0_im_o, bus.y1_re_o, bus.y1_im_o, bus.sat_o} !== {8'd64, 8'd0, 8'd0, 8'd0, 4'd0}) begin
      errors++;
      $display("FAIL unity_data: got y0=(%0d,%0d) y1=(%0d,%0d) sat=%b, required y0=(64,0) y1=(0,0) sat=0000",
               bus.y0_re_o, bus.y0_im_o, bus.y1_re_o, bus.y1_im_o, bus.sat_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_minus_j();
    int cyc;
    send(0, 0, 64, 0, 0, -16384);
    wait_out(cyc);
    checks++;
    if (cyc !== 3 || {bus.y0_re_o, bus.y0_im_o, bus.y1_re_o, bus.y1_im_o, bus.sat_o}
        !== {8'd0, 8'hE0, 8'd0, 8'd32, 4'd0}) begin
      errors++;
      $display("FAIL minus_j: got lat=%0d y0=(%0d,%0d) y1=(%0d,%0d), required lat=3 y0=(0,-32) y1=(0,32)",
               cyc, bus.y0_re_o, bus.y0_im_o, bus.y1_re_o, bus.y1_im_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_rounding();
    int cyc;
    send(1, -1, 0, 0, 16384, 0);
    wait_out(cyc);
    checks++;
    if (cyc !== 3 || {bus.y0_re_o, bus.y0_im_o, bus.y1_re_o, bus.y1_im_o, bus.sat_o}
        !== {8'd1, 8'd0, 8'd1, 8'd0, 4'd0}) begin
      errors++;
      $display("FAIL rounding: got lat=%0d y0=(%0d,%0d) y1=(%0d,%0d), required lat=3 y0=(1,0) y1=(1,0)",
               cyc, bus.y0_re_o, bus.y0_im_o, bus.y1_re_o, bus.y1_im_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_saturation();
    int cyc;
    send(255, -256, 255, -256, 16384, 0);
    wait_out(cyc);
    checks++;
    if (cyc !== 3 || {bus.y0_re_o, bus.y0_im_o} !== {8'd127, 8'h80} || bus.sat_o !== 4'b0011) begin
      errors++;
      $display("FAIL sat_y0: got lat=%0d y0=(%0d,%0d) sat=%b, required lat=3 y0=(127,-128) sat=0011",
               cyc, bus.y0_re_o, bus.y0_im_o, bus.sat_o);
    end
    checks++;
    if ({bus.y1_re_o, bus.y1_im_o} !== 16'd0) begin
      errors++;
      $display("FAIL sat_y1: got y1=(%0d,%0d), required (0,0)", bus.y1_re_o, bus.y1_im_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 50 && q.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d results still pending, required 0", name, q.size());
    end
  endtask

  task automatic test_back_to_back();
    int s0, p0;
    s0 = stalls;
    p0 = popped;
    bus.m_axis_tready = 1'b1;
    for (int i = 0; i < 6; i++) send_random();
    drain("b2b");
    checks++;
    if (stalls - s0 != 0 || popped - p0 != 6) begin
      errors++;
      $display("FAIL b2b_throughput: got stalls=%0d outputs=%0d, required stalls=0 outputs=6",
               stalls - s0, popped - p0);
    end
  endtask

  task automatic test_backpressure();
    int p0;
    bit done;
    p0 = popped;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_random();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus.m_axis_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.m_axis_tready = 1'b1;
    drain("bp");
    checks++;
    if (popped - p0 != 8) begin
      errors++;
      $display("FAIL bp_count: got %0d outputs, required 8", popped - p0);
    end
  endtask

  task automatic test_reset_midstream();
    int cyc;
    bus.m_axis_tready = 1'b1;
    for (int i = 0; i < 3; i++) send_random();
    rstn = 1'b0;
    #1;
    checks++;
    if ({bus.m_axis_tvalid, bus.s_axis_tready} !== 2'b01 ||
        {bus.y0_re_o, bus.y0_im_o, bus.y1_re_o, bus.y1_im_o, bus.sat_o} !== 36'd0) begin
      errors++;
      $display("FAIL midreset_clear: got m_tvalid=%b s_tready=%b data=%h, required 1'b0 1'b1 0",
               bus.m_axis_tvalid, bus.s_axis_tready,
               {bus.y0_re_o, bus.y0_im_o, bus.y1_re_o, bus.y1_im_o, bus.sat_o});
    end
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    send(64, 0, 64, 0, 16384, 0);
    wait_out(cyc);
    checks++;
    if (cyc !== 3 || {bus.y0_re_o, bus.y1_re_o} !== {8'd64, 8'd0}) begin
      errors++;
      $display("FAIL midreset_restart: got lat=%0d y0_re=%0d y1_re=%0d, required lat=3 64 0",
               cyc, bus.y0_re_o, bus.y1_re_o);
    end
    @(posedge clk);
    #1;
    drain("midreset");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    popped = 0;
    stalls = 0;
    rstn = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    bus.m_axis_tready = 1'b1;
    bus.a_re_i = '0;
    bus.a_im_i = '0;
    bus.b_re_i = '0;
    bus.b_im_i = '0;
    bus.w_re_i = '0;
    bus.w_im_i = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_unity();
    test_minus_j();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/butterfly_limiter.md
# butterfly_limiter

Radix-2 FFT butterfly datapath stage with rounding and output saturation, gated by a valid/ready stream handshake. It accepts one pre-shifted complex pair and one twiddle factor per transfer, computes the scaled butterfly y0 = (a + b·w)/2 and y1 = (a − b·w)/2, rounds the result and saturates it to the output data width. It sits inside the processing element, between the block-floating-point input shifter and the shift-amount producer.

## Interface
- DW, 8: output data width; values are signed Q2.(DW−2).
- IW, DW+1: input data width; values are signed Q3.(DW−2), one guard bit above DW.
- TW, 16: twiddle width; values are signed Q2.(TW−2), so 1.0 = 2^(TW−2).
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- s_axis_tvalid  in  1  input transfer valid.
- s_axis_tready  out  1  stage can accept an input.
- m_axis_tvalid  out  1  output transfer valid.
- m_axis_tready  in  1  downstream accepts the output.
- a_re_i, a_im_i, b_re_i, b_im_i  in  IW each  butterfly inputs a (x0) and b (x1), signed.
- w_re_i, w_im_i  in  TW each  twiddle factor, signed.
- y0_re_o, y0_im_o, y1_re_o, y1_im_o  out  DW each  butterfly outputs, signed.
- sat_o  out  4  per-output saturation flags, ordered y0_re, y0_im, y1_re, y1_im from bit 0; aligned with the data outputs.

## Operation
- Products are computed at full precision: p_re = b_re·w_re − b_im·w_im and p_im = b_re·w_im + b_im·w_re, each IW+TW+1 bits, with 2(DW−2)+… that is, (DW−2)+(TW−2) fractional bits.
- a is sign-extended and shifted left by TW−2 to align its binary point with p.
- s0 = a + p and s1 = a − p are formed without overflow, IW+TW+2 bits, per real and imaginary part.
- Scale and round: r = (s + 2^(TW−2)) >>> (TW−1), an arithmetic shift. This divides by 2 and rounds half toward +∞.
- Limit: if r > 2^(DW−1)−1, the output is 2^(DW−1)−1 and the matching sat bit is 1. If r < −2^(DW−1), the output is −2^(DW−1) and the sat bit is 1. Otherwise the output is r[DW−1:0] and the sat bit is 0.
- All arithmetic is two's complement. There is no internal state beyond the pipeline registers.

## Timing
- The pipeline has 3 register stages: stage 1 products, stage 2 sums, stage 3 round/limit to outputs. Latency from an accepted input to m_axis_tvalid is 3 cycles.
- Each stage carries a valid bit.
- Global advance: en = !m_axis_tvalid || m_axis_tready. s_axis_tready = en, a combinational function of m_axis_tready and the stage-3 valid bit.
- An input is accepted on a clock edge where s_axis_tvalid && s_axis_tready.
- When en = 0, all stages hold, including valid bits and data.
- While m_axis_tvalid && !m_axis_tready, all outputs remain stable.
- With m_axis_tready held at 1, throughput is 1 transfer per cycle.
- Bubbles (s_axis_tvalid = 0 while en = 1) propagate as invalid slots.
- Reset, including assertion mid-operation, clears all valid bits immediately. After reset: m_axis_tvalid = 0, all data outputs = 0, sat_o = 0. s_axis_tready reads 1 while in reset. In-flight data is discarded.
- Simultaneous output accept and input accept in the same cycle is legal, and no data is lost or duplicated.

## Test plan
- Unity twiddle, with DW = 8: a = (64, 0), b = (64, 0), w = (16384, 0) -> y0 = (64, 0), y1 = (0, 0), sat_o = 0, m_axis_tvalid 3 cycles after acceptance.
- Multiplication by −j: a = (0, 0), b = (64, 0), w = (0, −16384) -> y0 = (0, −32), y1 = (0, 32).
- Rounding: a = (1, −1), b = 0, w = (16384, 0) -> y0_re = 1, y0_im = 0, y1_re = 1, y1_im = 0.
- Saturation: a = (255, −256), b = (255, −256), w = (16384, 0) -> y0 = (127, −128) with sat_o[1:0] = 2'b11; y1 = (0, 0) with sat_o[3:2] = 0.
- Backpressure: stream 8 random vectors with m_axis_tready toggling pseudo-randomly -> outputs match the reference model in order with no loss or duplication, and outputs stay stable while stalled.
- Reset mid-stream: assert rstn = 0 with 3 transfers in flight -> m_axis_tvalid drops immediately and outputs are 0; after release, the first new input emerges 3 cycles after acceptance.
